// File: rtl/param_shift_register.sv
// Parametrised universal register: hold, parallel load, clear, or a multi-bit
// shift/rotate executed one bit per clock, with a busy/done handshake.
module param_shift_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             SHW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Handshake: start is sampled only on an edge where busy=0; done pulses for
    // exactly one cycle alongside the final data_out, and a start in that same
    // cycle is accepted.

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   n_clamped;
    logic [2:0]       op_sel;
    logic [WIDTH:0]   step_res;

    // One 1-bit step; returns {bit that left, new contents}.
    function automatic logic [WIDTH:0] step_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] d,
                                               input logic so,
                                               input logic si);
        logic [WIDTH:0] r;
        r = {so, d};
        case (op)
            M_SHL:   r = {d[WIDTH-1], d[WIDTH-2:0], si};
            M_SHR:   r = {d[0], si, d[WIDTH-1:1]};
            M_ROL:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            M_ROR:   r = {d[0], d[0], d[WIDTH-1:1]};
            M_ASR:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            default: r = {so, d};
        endcase
        return r;
    endfunction

    assign n_clamped = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
    assign op_sel    = (state_q == IDLE) ? mode : op_q;
    assign step_res  = step_fn(op_sel, data_q, ser_q, ser_in);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = mode;
                    case (mode)
                        M_HOLD: done_d = 1'b1;
                        M_LOAD: begin
                            data_d = data_in;
                            done_d = 1'b1;
                        end
                        M_CLR: begin
                            data_d = RESET_VAL;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (n_clamped == '0) begin
                                done_d = 1'b1;
                            end else begin
                                {ser_d, data_d} = step_res;
                                if (n_clamped == SHW'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = SHIFT;
                                    busy_d  = 1'b1;
                                    cnt_d   = n_clamped - SHW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                {ser_d, data_d} = step_res;
                // cnt holds the steps still owed, including this one.
                if (cnt_q != '0) cnt_d = cnt_q - SHW'(1);
                if (cnt_q <= SHW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= M_HOLD;
            cnt_q   <= '0;
            data_q  <= RESET_VAL;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = data_q;
    assign ser_out   = ser_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register (WIDTH=8, RESET_VAL=0): vector table, corner
// sequences and randomized commands against an arithmetic reference model.
module tb_param_shift_register;

    localparam int W   = 8;
    localparam int SHW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     mode;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   data_in;
    logic           ser_in;
    logic [W-1:0]   data_out;
    logic           ser_out;
    logic           busy;
    logic           done;
    logic           state_dbg;

    int checks   = 0;
    int failures = 0;

    param_shift_register #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt),
        .data_in(data_in), .ser_in(ser_in), .data_out(data_out),
        .ser_out(ser_out), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     mode;
        logic [SHW-1:0] shamt;
        logic [W-1:0]   din;
        logic           si;
        logic [W-1:0]   exp_data;
        logic           exp_ser;
        int             exp_lat;
    } vec_t;

    vec_t         vecs[$];
    logic [W:0]   exp_q[$];
    logic [W-1:0] trace[$];
    int           last_lat;
    int           last_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and wait (bounded) for its done pulse.
    task automatic run_cmd(input logic [2:0] m, input logic [SHW-1:0] sa,
                           input logic [W-1:0] din, input logic si);
        @(negedge clk);
        start = 1'b1; mode = m; shamt = sa; data_in = din; ser_in = si;
        @(posedge clk);
        #1 start = 1'b0;
        last_lat = 0;
        last_busy = 0;
        trace.delete();
        while (1) begin
            @(negedge clk);
            last_lat++;
            trace.push_back(data_out);
            if (busy) last_busy++;
            if (done) break;
            if (last_lat >= 40) begin
                check("done_timeout", done, 1);
                break;
            end
        end
    endtask

    // Whole-command result from the operation definitions: {ser_out, data_out}.
    function automatic logic [W:0] model(input logic [2:0] m, input int n_raw,
                                         input logic [W-1:0] d, input logic [W-1:0] din,
                                         input logic si, input logic so);
        logic [15:0]        t;
        logic [W-1:0]       r;
        logic signed [W-1:0] sd;
        int                 n;
        n = (n_raw > W) ? W : n_raw;
        if (m == 3'd0) return {so, d};
        if (m == 3'd1) return {so, din};
        if (m == 3'd7) return {so, 8'h00};
        if (n == 0) return {so, d};
        case (m)
            3'd2: begin
                t = {8'h00, d} << n;
                if (si) t = t | ((16'h1 << n) - 16'h1);
                return {t[8], t[7:0]};
            end
            3'd3: begin
                t = {d, 8'h00} >> n;
                if (si) t = t | ~(16'hFFFF >> n);
                return {t[7], t[15:8]};
            end
            3'd4: begin
                t = (16'(d) << n) | (16'(d) >> (W - n));
                r = t[7:0];
                return {r[0], r};
            end
            3'd5: begin
                t = (16'(d) >> n) | (16'(d) << (W - n));
                r = t[7:0];
                return {r[7], r};
            end
            default: begin
                sd = d;
                r = sd >>> n;
                t = 16'(d) >> (n - 1);
                return {t[0], r};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] m, input int n_raw);
        int n;
        n = (n_raw > W) ? W : n_raw;
        if (m >= 3'd2 && m <= 3'd6 && n >= 1) return n;
        return 1;
    endfunction

    logic [W-1:0] mdl_d;
    logic         mdl_s;
    logic [W:0]   expv;

    initial begin
        rst = 1'b0; start = 1'b0; mode = 3'd0; shamt = '0; data_in = '0; ser_in = 1'b0;

        vecs.push_back('{3'd1, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1});
        vecs.push_back('{3'd2, 4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 3});
        vecs.push_back('{3'd5, 4'd8,  8'h00, 1'b0, 8'h2F, 1'b0, 8});
        vecs.push_back('{3'd1, 4'd0,  8'h80, 1'b0, 8'h80, 1'b0, 1});
        vecs.push_back('{3'd6, 4'd2,  8'h00, 1'b0, 8'hE0, 1'b0, 2});
        vecs.push_back('{3'd1, 4'd0,  8'hFF, 1'b0, 8'hFF, 1'b0, 1});
        vecs.push_back('{3'd3, 4'd12, 8'h00, 1'b0, 8'h00, 1'b1, 8});
        vecs.push_back('{3'd0, 4'd5,  8'h33, 1'b0, 8'h00, 1'b1, 1});
        vecs.push_back('{3'd1, 4'd0,  8'h5A, 1'b0, 8'h5A, 1'b1, 1});
        vecs.push_back('{3'd4, 4'd0,  8'h00, 1'b0, 8'h5A, 1'b1, 1});
        vecs.push_back('{3'd7, 4'd3,  8'hFF, 1'b1, 8'h00, 1'b1, 1});
        vecs.push_back('{3'd1, 4'd0,  8'h81, 1'b0, 8'h81, 1'b1, 1});
        vecs.push_back('{3'd4, 4'd1,  8'h00, 1'b0, 8'h03, 1'b1, 1});
        vecs.push_back('{3'd2, 4'd8,  8'h00, 1'b0, 8'h00, 1'b1, 8});

        #12;
        check("reset_data", data_out, 8'h00);
        check("reset_ser", ser_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].mode, vecs[i].shamt, vecs[i].din, vecs[i].si);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_ser", i), ser_out, vecs[i].exp_ser);
            check($sformatf("vec%0d_lat", i), last_lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), last_busy, vecs[i].exp_lat - 1);
            if (i == 1) begin
                check("shl_trace_len", trace.size(), 3);
                if (trace.size() == 3) begin
                    check("shl_step1", trace[0], 8'h4B);
                    check("shl_step2", trace[1], 8'h97);
                end
            end
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
        end

        // Start while busy must not be latched.
        run_cmd(3'd1, 4'd0, 8'hFF, 1'b0);
        @(negedge clk);
        start = 1'b1; mode = 3'd3; shamt = 4'd12; ser_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        last_lat = 0;
        while (1) begin
            @(negedge clk);
            last_lat++;
            if (last_lat == 1) check("shift_state_dbg", state_dbg, 1);
            if (last_lat == 2) begin
                start = 1'b1; mode = 3'd1; data_in = 8'h11;
            end
            if (last_lat == 3) start = 1'b0;
            if (done) break;
            if (last_lat >= 40) begin
                check("busy_ign_timeout", done, 1);
                break;
            end
        end
        check("busy_ign_lat", last_lat, 8);
        check("busy_ign_data", data_out, 8'h00);
        @(negedge clk);
        check("busy_ign_after", data_out, 8'h00);

        // Back-to-back: new start in the done cycle is accepted.
        run_cmd(3'd2, 4'd1, 8'h00, 1'b1);
        check("b2b_first", data_out, 8'h01);
        start = 1'b1; mode = 3'd1; data_in = 8'h3C;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_data", data_out, 8'h3C);
        check("b2b_done", done, 1);

        // Asynchronous reset in the middle of a 6-bit shift.
        run_cmd(3'd1, 4'd0, 8'hFF, 1'b0);
        @(negedge clk);
        start = 1'b1; mode = 3'd2; shamt = 4'd6; ser_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_step3", data_out, 8'hF8);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ser", ser_out, 0);
        last_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) last_busy++;
        end
        check("mid_rst_no_done", last_busy, 0);
        rst = 1'b1;
        run_cmd(3'd1, 4'd0, 8'h77, 1'b0);
        check("post_rst_data", data_out, 8'h77);
        check("post_rst_lat", last_lat, 1);

        // Randomized commands against the reference model.
        mdl_d = 8'h77;
        mdl_s = 1'b0;
        for (int k = 0; k < 80; k++) begin
            logic [2:0]     m;
            logic [SHW-1:0] sa;
            logic [W-1:0]   din;
            logic           si;
            int             lat_e;
            m   = 3'($urandom_range(0, 7));
            sa  = SHW'($urandom_range(0, 15));
            din = W'($urandom);
            si  = 1'($urandom);
            expv = model(m, int'(sa), mdl_d, din, si, mdl_s);
            exp_q.push_back(expv);
            lat_e = model_lat(m, int'(sa));
            run_cmd(m, sa, din, si);
            expv = exp_q.pop_front();
            mdl_d = expv[W-1:0];
            mdl_s = expv[W];
            check($sformatf("rnd%0d_m%0d_s%0d_data", k, m, sa), data_out, mdl_d);
            check($sformatf("rnd%0d_m%0d_s%0d_ser", k, m, sa), ser_out, mdl_s);
            check($sformatf("rnd%0d_m%0d_s%0d_lat", k, m, sa), last_lat, lat_e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
